// File: rtl/seven_seg_scanner.sv
// ============================================================================
// seven_seg_scanner
//
// Time-multiplexed driver for the 8-digit common-anode seven-segment display
// on the Nexys A7. The CPU writes one segment pattern per digit into a small
// pattern memory. The scanner then cycles through the digits. Each digit's
// anode is on for ON_CYCLES clocks, and a BLANK_CYCLES gap with every anode
// off separates consecutive digits so that segment data from one digit does
// not ghost onto the next.
//
// Optional feature (compile-time macro):
//   SEVEN_SEG_HEX_DECODE_EN
//     Defined   : a write with hex_mode=1 stores the hex glyph of wr_data[3:0]
//                 in bits 6:0, and wr_data[7] becomes the decimal point.
//     Undefined : hex_mode is ignored, wr_data is always stored raw, and no
//                 decoder logic is built.
//
// Parameters:
//   NUM_DIGITS    digits scanned, 1..8
//   ON_CYCLES     clk cycles each digit's anode is on
//   BLANK_CYCLES  clk cycles with all anodes off between digits (>= 1)
//
// Ports:
//   clk         in   main clock
//   reset       in   asynchronous active-high reset
//   wr_en       in   write strobe, one cycle per write
//   wr_addr     in   [2:0] digit index to write (>= NUM_DIGITS is ignored)
//   wr_data     in   [7:0] active-high pattern, bit0=A .. bit6=G, bit7=DP
//   hex_mode    in   decode wr_data[3:0] as a hex glyph (macro builds only)
//   digit_en    in   [NUM_DIGITS-1:0] per-digit enable; 0 keeps anode off
//   seg_n       out  [7:0] active-low cathodes, registered
//   an_n        out  [7:0] active-low anodes, registered; unused bits high
//   frame_tick  out  one-cycle pulse when digit 0 turns on
// ============================================================================
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  hex_mode,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [7:0]            seg_n,
  output logic [7:0]            an_n,
  output logic                  frame_tick
);

  // The timer only needs to count to the longer of the two phase lengths.
  localparam int TIMER_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TIMER_W-1:0] ON_LAST     = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BLANK_LAST  = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]         DIGIT_COUNT = 4'(NUM_DIGITS);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  scan_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [7:0]         mem_q [NUM_DIGITS];

  logic               wr_valid;
  logic [IDX_W-1:0]   wr_idx;
  logic [7:0]         wr_value;
  logic [7:0]         read_data;

  logic [7:0]         seg_d;
  logic [7:0]         an_d;
  logic               tick_d;
  logic [2:0]         an_sel;

  // --------------------------------------------------------------------------
  // Write path. Out-of-range addresses are dropped here, so nothing outside
  // the pattern memory can ever be touched.
  // --------------------------------------------------------------------------
  assign wr_valid = wr_en && ({1'b0, wr_addr} < DIGIT_COUNT);
  assign wr_idx   = wr_addr[IDX_W-1:0];

`ifdef SEVEN_SEG_HEX_DECODE_EN
  // Standard hex glyphs, active-high, bit0=A .. bit6=G.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    glyph = 7'h00;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
    return glyph;
  endfunction

  // The decimal point passes straight through in hex mode.
  assign wr_value = hex_mode ? {wr_data[7], hex_glyph(wr_data[3:0])} : wr_data;
`else
  logic unused_hex_mode;
  assign unused_hex_mode = hex_mode;
  assign wr_value        = wr_data;
`endif

  // --------------------------------------------------------------------------
  // Pattern memory: one byte per digit, cleared by reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_valid) begin
      mem_q[wr_idx] <= wr_value;
    end
  end

  // A write to the digit being scanned is forwarded straight to the output
  // register, so the new pattern shows up one cycle after the write instead
  // of two.
  assign read_data = (wr_valid && (wr_idx == idx_q)) ? wr_value : mem_q[idx_q];

  // --------------------------------------------------------------------------
  // Scan state register: phase, phase timer and current digit index.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BLANK;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Every digit gets its full ON slot whether or not it is
  // enabled, which keeps brightness independent of the enable mask. The index
  // advances on the ON->BLANK transition, so each blank gap belongs to the
  // digit that just finished.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TIMER_W'(1);
    idx_d   = idx_q;
    unique case (state_q)
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          state_d = ST_ON;
          timer_d = '0;
        end
      end
      ST_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the current state. The outputs are registered, so
  // they trail the state by one cycle. Enables and written patterns are
  // resampled every cycle, so changes take effect mid-slot. Only one anode
  // bit can ever be cleared, and bits at or above NUM_DIGITS stay high.
  // --------------------------------------------------------------------------
  assign an_sel = 3'(idx_q);

  always_comb begin
    an_d   = 8'hFF;
    seg_d  = 8'hFF;
    tick_d = 1'b0;
    if (state_q == ST_ON) begin
      an_d[an_sel] = ~digit_en[idx_q];
      seg_d        = ~read_data;
      tick_d       = (idx_q == '0) && (timer_q == '0);
    end
  end

  // Registered pin drive; reset forces every line inactive immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n      <= 8'hFF;
      an_n       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      an_n       <= an_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// tb_seven_seg_scanner
//
// Drives two scanners side by side, one with 8 digits and one with 6, both
// using ON_CYCLES=4 and BLANK_CYCLES=1. A cycle-count model predicts every
// output. It works out, from the number of edges since reset, which digit
// (if any) must be lit, and keeps its own copy of the pattern memory.
// Directed sequences with hand-computed values pin that model down.
// ============================================================================
module tb_seven_seg_scanner;

  localparam int ON_CYC    = 4;
  localparam int BLANK_CYC = 1;
  localparam int SLOT      = ON_CYC + BLANK_CYC;

  // Expected seg_n for digit 5 after writing 0x8A with hex_mode=1.
  localparam logic [7:0] HEX_WRITE_SEG =
`ifdef SEVEN_SEG_HEX_DECODE_EN
    8'h08;
`else
    8'h75;
`endif

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       hex_mode;
  logic [7:0] digit_en;

  logic [7:0] seg8, an8, seg6, an6;
  logic       tick8, tick6;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  seven_seg_scanner #(
    .NUM_DIGITS  (8),
    .ON_CYCLES   (ON_CYC),
    .BLANK_CYCLES(BLANK_CYC)
  ) dut8 (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hex_mode  (hex_mode),
    .digit_en  (digit_en),
    .seg_n     (seg8),
    .an_n      (an8),
    .frame_tick(tick8)
  );

  seven_seg_scanner #(
    .NUM_DIGITS  (6),
    .ON_CYCLES   (ON_CYC),
    .BLANK_CYCLES(BLANK_CYC)
  ) dut6 (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hex_mode  (hex_mode),
    .digit_en  (digit_en[5:0]),
    .seg_n     (seg6),
    .an_n      (an6),
    .frame_tick(tick6)
  );

  // Free-running clock and a cycle counter for period measurements.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Reference model.
  // --------------------------------------------------------------------------
  logic [7:0] m8 [8];
  logic [7:0] m6 [6];
  int         edges_since_reset;
  bit         model_valid = 1'b0;
  int         d8, d6;
  logic [7:0] exp_seg8, exp_an8, exp_seg6, exp_an6;
  logic       exp_tick8, exp_tick6;

  function automatic logic [7:0] encode(input logic [7:0] d, input logic hm);
`ifdef SEVEN_SEG_HEX_DECODE_EN
    logic [6:0] g;
    if (hm) begin
      g = 7'h00;
      case (d[3:0])
        4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
        4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
        4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
        4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  4'hF: g = 7'h71;
        default: g = 7'h00;
      endcase
      return {d[7], g};
    end
`endif
    return hm ? d : d;
  endfunction

  // Which digit is lit after the given number of edges since reset, or -1.
  // The first lit edge is BLANK_CYC+1; after that the pattern repeats every
  // frame of nd slots, each slot being ON_CYC lit cycles then a blank gap.
  function automatic int lit_digit(input int n, input int nd);
    int q;
    if (n < BLANK_CYC + 1) return -1;
    q = (n - BLANK_CYC - 1) % (nd * SLOT);
    if ((q % SLOT) >= ON_CYC) return -1;
    return q / SLOT;
  endfunction

  function automatic bit frame_start(input int n, input int nd);
    if (n < BLANK_CYC + 1) return 1'b0;
    return ((n - BLANK_CYC - 1) % (nd * SLOT)) == 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edges_since_reset = 0;
      for (int i = 0; i < 8; i++) m8[i] = 8'h00;
      for (int i = 0; i < 6; i++) m6[i] = 8'h00;
      exp_seg8 = 8'hFF; exp_an8 = 8'hFF; exp_tick8 = 1'b0;
      exp_seg6 = 8'hFF; exp_an6 = 8'hFF; exp_tick6 = 1'b0;
      model_valid = 1'b1;
    end else begin
      edges_since_reset = edges_since_reset + 1;
      if (wr_en) begin
        m8[wr_addr] = encode(wr_data, hex_mode);
        if (wr_addr < 3'd6) m6[wr_addr] = encode(wr_data, hex_mode);
      end
      d8 = lit_digit(edges_since_reset, 8);
      d6 = lit_digit(edges_since_reset, 6);
      exp_an8 = 8'hFF; exp_seg8 = 8'hFF;
      exp_an6 = 8'hFF; exp_seg6 = 8'hFF;
      if (d8 >= 0) begin
        exp_an8[d8] = ~digit_en[d8];
        exp_seg8    = ~m8[d8];
      end
      if (d6 >= 0) begin
        exp_an6[d6] = ~digit_en[d6];
        exp_seg6    = ~m6[d6];
      end
      exp_tick8 = frame_start(edges_since_reset, 8);
      exp_tick6 = frame_start(edges_since_reset, 6);
    end
  end

  // --------------------------------------------------------------------------
  // Tasks.
  // --------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  // Compare every output of both scanners against the model on each falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_an8",   an8,   exp_an8);
      checkOutput("model_seg8",  seg8,  exp_seg8);
      checkOutput("model_tick8", tick8, exp_tick8);
      checkOutput("model_an6",   an6,   exp_an6);
      checkOutput("model_seg6",  seg6,  exp_seg6);
      checkOutput("model_tick6", tick6, exp_tick6);
    end
  end

  task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data,
                               input logic hm);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    hex_mode = hm;
    @(negedge clk);
    wr_en    = 1'b0;
    hex_mode = 1'b0;
  endtask

  // Called right after reset is released on a falling edge.
  task automatic waitFirstAnode();
    int  edges;
    bit  found;
    edges = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (an8 != 8'hFF) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("first_anode_found", 32'(found), 32'd1);
    checkOutput("first_anode_edges", edges, 2);
    checkOutput("first_anode_an", an8, 8'hFE);
    checkOutput("first_anode_tick", tick8, 1'b1);
  endtask

  task automatic waitAnode(input bit six, input logic [7:0] pat, output bit found);
    found = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if ((six ? an6 : an8) == pat) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(six ? "wait_an6" : "wait_an8", 32'(found), 32'd1);
  endtask

  task automatic waitTick(input bit six, output int at);
    bit found;
    found = 1'b0;
    at    = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (six ? tick6 : tick8) begin
        found = 1'b1;
        at    = cyc;
        break;
      end
    end
    checkOutput(six ? "wait_tick6" : "wait_tick8", 32'(found), 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence.
  // --------------------------------------------------------------------------
  initial begin
    bit   found;
    bit   low_seen;
    bit   high_ok;
    int   t1, t2;

    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 8'h00;
    hex_mode = 1'b0;
    digit_en = 8'hFF;
    #1 reset = 1'b1;

    // Power-on reset values.
    repeat (2) @(negedge clk);
    checkOutput("reset_an8",   an8,   8'hFF);
    checkOutput("reset_seg8",  seg8,  8'hFF);
    checkOutput("reset_tick8", tick8, 1'b0);
    reset = 1'b0;
    waitFirstAnode();

    // Raw write to digit 2, then watch its whole slot.
    applyStimulus(3'd2, 8'h5B, 1'b0);
    waitAnode(1'b0, 8'hFB, found);
    for (int i = 0; i < ON_CYC; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("slot2_an",  an8,  8'hFB);
      checkOutput("slot2_seg", seg8, 8'hA4);
    end
    @(negedge clk);
    checkOutput("slot2_gap_an",  an8,  8'hFF);
    checkOutput("slot2_gap_seg", seg8, 8'hFF);

    // Reset while digit 3 is lit.
    applyStimulus(3'd3, 8'h4F, 1'b0);
    waitAnode(1'b0, 8'hF7, found);
    checkOutput("slot3_seg", seg8, 8'hB0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_an8",   an8,   8'hFF);
    checkOutput("midreset_seg8",  seg8,  8'hFF);
    checkOutput("midreset_tick8", tick8, 1'b0);
    checkOutput("midreset_an6",   an6,   8'hFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    waitFirstAnode();

    // Write digit 0 during its second lit cycle.
    @(posedge clk);
    #1;
    checkOutput("d0_before_seg", seg8, 8'hFF);
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'h06;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checkOutput("d0_after_seg", seg8, 8'hF9);
    checkOutput("d0_after_an",  an8,  8'hFE);

    // All digits disabled for a full frame.
    @(negedge clk);
    digit_en = 8'h00;
    waitTick(1'b0, t1);
    low_seen = 1'b0;
    t2 = t1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (an8 != 8'hFF) low_seen = 1'b1;
      if (tick8) begin
        t2 = cyc;
        break;
      end
    end
    checkOutput("masked_any_anode_low", 32'(low_seen), 32'd0);
    checkOutput("frame_period8", t2 - t1, 40);
    digit_en = 8'hFF;

    // Hex-mode write to digit 5 in both scanners.
    applyStimulus(3'd5, 8'h8A, 1'b1);
    waitAnode(1'b0, 8'hDF, found);
    checkOutput("hex_seg8", seg8, HEX_WRITE_SEG);
    waitAnode(1'b1, 8'hDF, found);
    checkOutput("hex_seg6", seg6, HEX_WRITE_SEG);

    // Addresses 6 and 7 exist only in the 8-digit scanner.
    applyStimulus(3'd7, 8'h12, 1'b0);
    applyStimulus(3'd6, 8'h40, 1'b0);
    waitAnode(1'b0, 8'h7F, found);
    checkOutput("addr7_seg8", seg8, 8'hED);
    waitAnode(1'b1, 8'hFE, found);
    checkOutput("six_d0_seg6", seg6, 8'hF9);
    waitTick(1'b1, t1);
    high_ok = 1'b1;
    t2 = t1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (an6[7:6] != 2'b11) high_ok = 1'b0;
      if (tick6) begin
        t2 = cyc;
        break;
      end
    end
    checkOutput("six_high_anodes", 32'(high_ok), 32'd1);
    checkOutput("frame_period6", t2 - t1, 30);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the 8-digit common-anode seven-segment display on the Nexys A7 platform. It takes per-digit segment patterns written by the CPU GPIO/peripheral logic and drives the CA..DP cathode lines and AN0..AN7 anode lines. Digits are scanned continuously, with a blanking gap between digits to suppress ghosting. It sits between the processor platform's output registers and the board pins, replacing static single-pattern drive.

## Interface
- NUM_DIGITS, 8: digits scanned, 1..8.
- ON_CYCLES, 100000: clk cycles each digit's anode is on.
- BLANK_CYCLES, 2000: clk cycles with all anodes off between digits; ≥1.
- clk  in  1  main clock.
- reset  in  1  asynchronous, active-high reset. One clock domain, no internal synchronizer.
- wr_en  in  1  write strobe, one cycle per write.
- wr_addr  in  3  digit index to write. Writes with wr_addr ≥ NUM_DIGITS are ignored.
- wr_data  in  8  segment pattern, active-high: bit0=A … bit6=G, bit7=DP.
- hex_mode  in  1  on write, decode wr_data[3:0] as hex (see Configuration).
- digit_en  in  NUM_DIGITS  per-digit enable. 0 keeps that digit's anode off during its slot.
- seg_n  out  8  cathodes, active-low, registered.
- an_n  out  8  anodes, active-low, registered. Bits ≥ NUM_DIGITS are held at 1.
- frame_tick  out  1  one-cycle pulse when digit 0 enters ON.

## Operation
- Pattern memory: NUM_DIGITS×8 flops, reset to 0x00.
  - Write occurs at the wr_en edge.
  - A write and a scan read of the same digit in the same cycle: the new value is visible on seg_n the next cycle.
- FSM has two states, BLANK and ON.
  - Reset → BLANK, digit index 0, timer 0.
  - BLANK: count BLANK_CYCLES, then → ON for the current index.
  - ON: count ON_CYCLES, then → BLANK and increment the index. The index wraps NUM_DIGITS-1 → 0.
- Output drive in ON for digit k:
  - an_n[k] = ~digit_en[k]; all other anode bits are 1.
  - seg_n = ~mem[k].
  - Both are re-evaluated every cycle, so digit_en and writes take effect mid-slot with one cycle of latency.
- Output drive in BLANK: an_n = 0xFF, seg_n = 0xFF.
- A disabled digit still consumes its full slot, so brightness is uniform and independent of the mask.
- Reset mid-scan: all outputs return to 1 asynchronously, memory clears, and the scan restarts at BLANK, digit 0.
- The timer is sized with $clog2 of max(ON_CYCLES, BLANK_CYCLES). No other arithmetic.

## Timing
- Reset values: seg_n=0xFF, an_n=0xFF, frame_tick=0.
- After reset deasserts, the first anode goes low BLANK_CYCLES+1 edges later, at digit 0, coincident with frame_tick=1.
- Each digit is low for exactly ON_CYCLES cycles, followed by exactly BLANK_CYCLES cycles of all-off.
- Frame period = NUM_DIGITS×(ON_CYCLES+BLANK_CYCLES) cycles.
- frame_tick pulses exactly once per frame.
- Write to display latency: at most one frame, or 1 cycle if the target digit is currently in its ON slot.
- At no cycle is more than one an_n bit low.

## Configuration
- SEVEN_SEG_HEX_DECODE_EN defined:
  - A write with hex_mode=1 stores the standard hex glyph of wr_data[3:0] in bits 6:0.
  - Glyphs: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
  - Bit7 = wr_data[7]. wr_data[6:4] is ignored.
- SEVEN_SEG_HEX_DECODE_EN undefined: hex_mode is ignored and wr_data is always stored raw. No decoder logic is synthesized.

## Test plan
Bench uses ON_CYCLES=4, BLANK_CYCLES=1, NUM_DIGITS=8.
- Reset pulse mid-ON of digit 3 → an_n=0xFF and seg_n=0xFF within the reset cycle. After release, frame_tick and an_n=0xFE occur 2 edges later.
- Write digit 2 raw 0x5B with digit_en=0xFF → during slot 2, an_n=0xFB and seg_n=0xA4 for 4 cycles, then 1 cycle of 0xFF/0xFF.
- digit_en=0x00 for a full frame → an_n stays 0xFF, and the frame_tick period is still 40 cycles.
- Write digit 0 = 0x06 on the 2nd ON cycle of digit 0 → seg_n changes to 0xF9 on the next cycle. The anode does not glitch.
- With the macro defined, write addr 5, hex_mode=1, wr_data=0x8A → mem[5]=0xF7 and seg_n=0x08 in slot 5. Without the macro → mem[5]=0x8A.
- wr_addr=7 with NUM_DIGITS=6 → memory unchanged, an_n[7:6] always 1, and the frame is 30 cycles.
